// File: rtl/dlx_debug_pkg.sv
// Shared definitions for the DLX host-debug path: loader states, command bytes
// and the default memory geometry used by the UART, memory wrapper and loader.
package dlx_debug_pkg;

    localparam int DLX_ADDR_W = 10;
    localparam int DLX_WORD_W = 32;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_HALT = 8'h48;
    localparam logic [7:0] CMD_STEP = 8'h53;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_BYTE   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_RUN    = 3'd5
    } loader_state_e;

    // A program length is usable when it is non-zero and fits the address space.
    function automatic logic len_in_range(input logic [15:0] n, input int addr_w);
        return (n != 16'd0) && (int'(n) <= (1 << addr_w));
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects four bytes MSB-first into one instruction word; word_ready_o flags
// the shift that completes the word.
module word_assembler #(
    parameter int WORD_W = 32
) (
    input  logic              clk_sys_i,
    input  logic              rst_b_i,
    input  logic              clear_i,
    input  logic              shift_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_ready_o
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [1:0]        cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (shift_i) begin
            word_d = {word_q[WORD_W-9:0], byte_i};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o       = word_q;
    assign word_ready_o = shift_i && !clear_i && (cnt_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Host-side program loader and run control for the DLX pipeline.
// state    | meaning
// IDLE     | waiting for a command byte
// LEN_HI   | capturing word count, high byte
// LEN_LO   | capturing word count, low byte, then range check
// BYTE     | collecting the four bytes of the current word
// WRITE    | one-cycle memory write strobe, receiver stalled
// RUN      | pipeline free-running until HALT
module program_loader
    import dlx_debug_pkg::*;
#(
    parameter int ADDR_W = DLX_ADDR_W,
    parameter int WORD_W = DLX_WORD_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_enable,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              error
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

    loader_state_e     state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [ADDR_W:0]   count_n_q, count_n_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cpu_en_q, cpu_en_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic [15:0]       len_word;
    logic [ADDR_W:0]   word_cnt_inc;
    logic              asm_clear, asm_shift, word_ready;
    logic [WORD_W-1:0] asm_word;

    assign rx_ready     = (state_q != ST_WRITE);
    assign accept       = rx_valid && rx_ready;
    assign len_word     = {len_hi_q, rx_data};
    assign word_cnt_inc = word_cnt_q + CNT_ONE;

    word_assembler #(.WORD_W(WORD_W)) u_asm (
        .clk_sys_i    (clock),
        .rst_b_i      (reset),
        .clear_i      (asm_clear),
        .shift_i      (asm_shift),
        .byte_i       (rx_data),
        .word_o       (asm_word),
        .word_ready_o (word_ready)
    );

    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        count_n_d  = count_n_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        cpu_en_d   = 1'b0;
        cpu_rst_d  = cpu_rst_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        asm_clear  = 1'b0;
        asm_shift  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (rx_data)
                        CMD_LOAD: begin
                            state_d   = ST_LEN_HI;
                            cpu_rst_d = 1'b1;
                        end
                        CMD_RUN: begin
                            state_d   = ST_RUN;
                            cpu_rst_d = 1'b0;
                            cpu_en_d  = 1'b1;
                        end
                        CMD_STEP: begin
                            cpu_rst_d = 1'b0;
                            cpu_en_d  = 1'b1;
                        end
                        CMD_HALT: ;
                        default:  err_d = 1'b1;
                    endcase
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_hi_d = rx_data;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    if (len_in_range(len_word, ADDR_W)) begin
                        count_n_d  = len_word[ADDR_W:0];
                        word_cnt_d = '0;
                        addr_d     = '0;
                        asm_clear  = 1'b1;
                        state_d    = ST_BYTE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_BYTE: begin
                if (accept) begin
                    asm_shift = 1'b1;
                    if (word_ready) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                word_cnt_d = word_cnt_inc;
                // Saturate so the final word of a full-size image leaves the last address visible.
                addr_d     = (addr_q == ADDR_LAST) ? addr_q : addr_q + 1'b1;
                if (word_cnt_inc == count_n_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BYTE;
                end
            end
            ST_RUN: begin
                cpu_en_d = 1'b1;
                if (accept && (rx_data == CMD_HALT)) begin
                    cpu_en_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            len_hi_q   <= '0;
            count_n_q  <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
            cpu_en_q   <= 1'b0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            count_n_q  <= count_n_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            cpu_en_q   <= cpu_en_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign imem_we    = (state_q == ST_WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = asm_word;
    assign cpu_enable = cpu_en_q;
    assign cpu_reset  = cpu_rst_q;
    assign load_done  = done_q;
    assign error      = err_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream host-interface stage for the MIPS_DLX pipeline.
- Consumes a byte stream from the UART receiver through a valid/ready handshake and assembles 32-bit instruction words, MSB first.
- Writes those words into instruction memory at the 10-bit PC address space.
- Gates the pipeline with cpu_enable and cpu_reset to give load, run, halt and single-step control.

Parameters:
- ADDR_W, 10: instruction memory address width; matches PC width.
- WORD_W, 32: instruction word width.
- CMD_LOAD, 8'h4C: 'L', load program.
- CMD_RUN, 8'h52: 'R', free run.
- CMD_HALT, 8'h48: 'H', stop run.
- CMD_STEP, 8'h53: 'S', advance one clock.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  rx_data holds a valid byte.
- rx_ready  out  1  loader accepts the byte this cycle; transfer occurs when rx_valid && rx_ready.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  WORD_W  assembled word.
- cpu_enable  out  1  pipeline clock enable.
- cpu_reset  out  1  active-high reset to the pipeline latches and PC.
- load_done  out  1  one-cycle pulse after the last word is written.
- error  out  1  one-cycle pulse on a bad command or bad length.

Behaviour:
- Reset values (reset low): state IDLE; imem_we=0, imem_addr=0, imem_wdata=0; cpu_enable=0; cpu_reset=1; load_done=0; error=0; rx_ready=1; byte counter and word counter cleared.
- States: IDLE, LEN_HI, LEN_LO, BYTE, WRITE, RUN.
- IDLE, on an accepted byte:
  - CMD_LOAD -> LEN_HI, and assert cpu_reset=1.
  - CMD_RUN -> RUN, with cpu_reset=0 and cpu_enable=1 from the next cycle.
  - CMD_STEP -> stay in IDLE; cpu_reset=0 and cpu_enable=1 for exactly one cycle (the cycle after acceptance), then 0.
  - CMD_HALT -> ignored.
  - Any other byte -> error pulse next cycle; stay in IDLE.
- LEN_HI / LEN_LO: capture a 16-bit word count N, high byte first.
  - If N==0 or N>2**ADDR_W, pulse error and return to IDLE. cpu_reset stays 1.
  - Otherwise go to BYTE with imem_addr=0 and the byte counter at 0.
- BYTE: each accepted byte shifts into imem_wdata from the LSB end, so the first byte ends in [31:24]. After the 4th byte go to WRITE.
- WRITE (exactly one cycle):
  - imem_we=1 with the current imem_addr and imem_wdata; rx_ready=0.
  - Next cycle: imem_addr increments and the word counter increments.
  - If the word counter reaches N: pulse load_done, go to IDLE.
  - Otherwise go back to BYTE.
- RUN:
  - cpu_enable held at 1.
  - An accepted CMD_HALT sets cpu_enable=0 the next cycle and returns to IDLE; cpu_reset stays 0, so pipeline state is preserved.
  - All other bytes are accepted and discarded.
- rx_ready is 1 in every state except WRITE.
- Load latency: the write strobe occurs 1 cycle after the 4th byte of a word is accepted.
- imem_addr never wraps, because N is bounded to 2**ADDR_W. At N=1024 the last write is at address 1023, and imem_addr then holds 1023 (it saturates).
- Simultaneous events: rx_valid during WRITE is not accepted; the UART receiver buffers the byte.
- Mid-operation reset: everything returns to its reset values asynchronously and any partial word is discarded. Words already written stay in memory.
- cpu_reset is deasserted only by a RUN or STEP command. A later CMD_LOAD re-asserts it.

Decomposition:
- Shared package (dlx_debug_pkg) holds:
  - the state enumeration;
  - the CMD_* byte constants;
  - ADDR_W and WORD_W defaults, so the UART receiver, the memory wrapper and this block agree.
- One natural sub-module, word_assembler: a byte shift register with a 2-bit byte counter and a word_ready output.
- The FSM, counters and CPU gating stay in program_loader.

Test Plan:
- Reset released, no input -> cpu_reset=1, cpu_enable=0, rx_ready=1, all other outputs 0.
- Send 4C 00 02 DE AD BE EF 01 23 45 67 -> imem_we pulses twice: addr 0 with 0xDEADBEEF, then addr 1 with 0x01234567. load_done pulses 1 cycle after the second write. rx_ready=0 exactly during each write cycle.
- Send 4C 00 00, then 4C 04 01 -> one error pulse after each length; no imem_we; state returns to IDLE.
- Send 53, three times -> three isolated 1-cycle cpu_enable pulses; cpu_reset drops to 0 at the first one.
- Send 52, wait 20 cycles, send 4C then 48 -> cpu_enable high for the whole span; 4C is ignored; cpu_enable is 0 on the cycle after 48 is accepted.
- Send 4C 00 01 AA BB, then pull reset low -> all outputs at reset values immediately. After release, send 4C 00 01 11 22 33 44 -> single write of 0x11223344 at addr 0.
- Send 7A -> one error pulse; a following 53 still produces a step.
